rf_port_arbiter: RTL and testbench

- Shares the single-read-pair / single-write-port 32x32 register file between NUM_REQ requesters (e.g. decode, writeback, debug, load unit).
- Grants one requester per cycle using round-robin, then drives the register file address, write enable and write data.
- Returns the two read operands one cycle later, tagged with the requester ID.
- Also sequences a one-cycle register-file clear on request.

---
 rtl/rf_port_arbiter_pkg.sv | 25 ++
 rtl/rf_port_arbiter_if.sv | 36 +++
 rtl/rf_port_arbiter_rr_arbiter.sv | 39 +++
 rtl/rf_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_rf_port_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter.
//   REG_IDX_W / DATA_W : register index and data widths of the 32x32 file
//   FLAT_IDX_W         : width of the widest flattened index bus (8 requesters)
//   state_e            : arbiter FSM states
//   idx_field()        : pulls one requester's 5-bit index out of a flat bus
package rf_arb_pkg;

   localparam int REG_IDX_W  = 5;
   localparam int DATA_W     = 32;
   localparam int MAX_REQ    = 8;
   localparam int FLAT_IDX_W = MAX_REQ * REG_IDX_W;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Requester sel owns bits [5*sel+4 : 5*sel]; the caller zero-extends its
   // bus to FLAT_IDX_W so one function serves every NUM_REQ.
   function automatic logic [REG_IDX_W-1:0] idx_field(input logic [FLAT_IDX_W-1:0] flat,
                                                      input int                    sel);
      idx_field = REG_IDX_W'(flat >> (sel * REG_IDX_W));
   endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter.
//   req_valid/req_ready : per-requester handshake, one-hot ready
//   req_rs/rt/rd        : flattened 5-bit indices, requester i at [5i+4:5i]
//   req_we/req_wdata    : write request and flattened 32-bit write data
//   resp_valid/resp_id  : read response strobe and owning requester
//   resp_data1/2        : read operands
// master = requester side, slave = arbiter side.
interface rf_port_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   import rf_arb_pkg::*;

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*REG_IDX_W-1:0] req_rs;
   logic [NUM_REQ*REG_IDX_W-1:0] req_rt;
   logic [NUM_REQ*REG_IDX_W-1:0] req_rd;
   logic [NUM_REQ-1:0]           req_we;
   logic [NUM_REQ*DATA_W-1:0]    req_wdata;
   logic                         resp_valid;
   logic [ID_W-1:0]              resp_id;
   logic [DATA_W-1:0]            resp_data1;
   logic [DATA_W-1:0]            resp_data2;

   modport master (
      output req_valid, req_rs, req_rt, req_rd, req_we, req_wdata,
      input  req_ready, resp_valid, resp_id, resp_data1, resp_data2
   );

   modport slave (
      input  req_valid, req_rs, req_rt, req_rd, req_we, req_wdata,
      output req_ready, resp_valid, resp_id, resp_data1, resp_data2
   );

endinterface

// File: rtl/rf_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index searched first; the search wraps N-1 -> 0
//   gnt     : one-hot grant
//   gnt_id  : encoded index of the grant
//   gnt_any : some request was granted
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_any
);

   int              idx;
   logic [ID_W-1:0] sel;

   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = idx[ID_W-1:0];
         if (!gnt_any && req[sel]) begin
            gnt[sel] = 1'b1;
            gnt_id   = sel;
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one read-pair / one write-port 32x32 register file between NUM_REQ
// requesters. One round-robin grant per cycle drives the file's address,
// write enable and write data combinationally; the registered read data comes
// back one cycle later tagged with the requester ID. A clear_req pulse runs a
// one-cycle whole-file clear (rf_reset) during which nothing is granted.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   bus (slave)          : requester handshake, request fields and response
//   clear_req            : pulse requesting a register-file clear
//   clear_busy           : a clear is pending or executing
//   rf_regs/regt/regd    : register-file addresses
//   rf_regWrite          : register-file write enable
//   rf_reset             : register-file clear strobe (also high in reset)
//   rf_dataWrite         : register-file write data
//   rf_reg1/rf_reg2      : register-file read data, already registered
//
// Build option RF_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module rf_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   rf_port_arbiter_if.slave     bus,
   input  logic                 clear_req,
   output logic                 clear_busy,
   output logic [REG_IDX_W-1:0] rf_regs,
   output logic [REG_IDX_W-1:0] rf_regt,
   output logic [REG_IDX_W-1:0] rf_regd,
   output logic                 rf_regWrite,
   output logic                 rf_reset,
   output logic [DATA_W-1:0]    rf_dataWrite,
   input  logic [DATA_W-1:0]    rf_reg1,
   input  logic [DATA_W-1:0]    rf_reg2
);

   state_e               state;
   logic                 clear_pend;
   logic [ID_W-1:0]      ptr;
   logic                 arb_en;
   logic [NUM_REQ-1:0]   req_p0;
   logic [NUM_REQ-1:0]   gnt_p0;
   logic [ID_W-1:0]      gnt_id_p0;
   logic                 gnt_any_p0;
   logic [FLAT_IDX_W-1:0] rs_flat;
   logic [FLAT_IDX_W-1:0] rt_flat;
   logic [FLAT_IDX_W-1:0] rd_flat;
   logic                 vld_p1;
   logic [ID_W-1:0]      id_p1;
   logic                 resp_ok;
`ifdef RF_ZERO_REG_EN
   logic [REG_IDX_W-1:0] rs_p1;
   logic [REG_IDX_W-1:0] rt_p1;
`endif

   // ---- stage p0: arbitration and register-file drive ----
   // A latched clear blocks grants in the RUN cycle before its CLEAR too.
   assign arb_en = ~reset & (state == ST_RUN) & ~clear_pend;
   assign req_p0 = bus.req_valid & {NUM_REQ{arb_en}};

   rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req     (req_p0),
      .ptr     (ptr),
      .gnt     (gnt_p0),
      .gnt_id  (gnt_id_p0),
      .gnt_any (gnt_any_p0)
   );

   assign bus.req_ready = gnt_p0;

   assign rs_flat = FLAT_IDX_W'(bus.req_rs);
   assign rt_flat = FLAT_IDX_W'(bus.req_rt);
   assign rd_flat = FLAT_IDX_W'(bus.req_rd);

   always_comb begin
      rf_regs      = '0;
      rf_regt      = '0;
      rf_regd      = '0;
      rf_regWrite  = 1'b0;
      rf_dataWrite = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_p0[i]) begin
            rf_regs      = idx_field(rs_flat, i);
            rf_regt      = idx_field(rt_flat, i);
            rf_regd      = idx_field(rd_flat, i);
            rf_regWrite  = bus.req_we[i];
            rf_dataWrite = DATA_W'(bus.req_wdata >> (i * DATA_W));
         end
      end
`ifdef RF_ZERO_REG_EN
      if (rf_regd == '0) rf_regWrite = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (gnt_any_p0) begin
         ptr <= (gnt_id_p0 == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_p0 + 1'b1;
      end
   end

   // CLEAR lasts one cycle; a clear_req seen during it is held in clear_pend
   // and re-enters CLEAR after one blocked RUN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RUN;
         clear_pend <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (clear_req || clear_pend) begin
                  state      <= ST_CLEAR;
                  clear_pend <= 1'b0;
               end
            end
            ST_CLEAR: begin
               state <= ST_RUN;
               if (clear_req) clear_pend <= 1'b1;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign clear_busy = ~reset & ((state == ST_CLEAR) | clear_pend);
   assign rf_reset   = reset | (state == ST_CLEAR);

   // ---- stage p1: response, data comes straight from the registered file ----
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= gnt_any_p0;
   end

   always_ff @(posedge clk) begin
      id_p1 <= gnt_id_p0;
`ifdef RF_ZERO_REG_EN
      rs_p1 <= rf_regs;
      rt_p1 <= rf_regt;
`endif
   end

   // Reset also masks a response that was already in flight.
   assign resp_ok        = vld_p1 & ~reset;
   assign bus.resp_valid = resp_ok;
   assign bus.resp_id    = resp_ok ? id_p1 : '0;
`ifdef RF_ZERO_REG_EN
   assign bus.resp_data1 = (resp_ok && rs_p1 != '0) ? rf_reg1 : '0;
   assign bus.resp_data2 = (resp_ok && rt_p1 != '0) ? rf_reg2 : '0;
`else
   assign bus.resp_data1 = resp_ok ? rf_reg1 : '0;
   assign bus.resp_data2 = resp_ok ? rf_reg2 : '0;
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter with a behavioural 32x32 register
// file (registered read, read-before-write, whole-file clear on rf_reset).
// A table of single-cycle vectors covers transfers, hazards, clears and reset;
// hand-written sequences cover round-robin rotation and register 0.
module tb_rf_port_arbiter;
   import rf_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear_req;
   logic        clear_busy;
   logic [4:0]  rf_regs, rf_regt, rf_regd;
   logic        rf_regWrite, rf_reset;
   logic [31:0] rf_dataWrite, rf_reg1, rf_reg2;
   logic [31:0] regs [32];

   int n_cmp = 0;
   int n_bad = 0;

   rf_port_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

   rf_port_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .clear_req    (clear_req),
      .clear_busy   (clear_busy),
      .rf_regs      (rf_regs),
      .rf_regt      (rf_regt),
      .rf_regd      (rf_regd),
      .rf_regWrite  (rf_regWrite),
      .rf_reset     (rf_reset),
      .rf_dataWrite (rf_dataWrite),
      .rf_reg1      (rf_reg1),
      .rf_reg2      (rf_reg2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      end else if (rf_regWrite) begin
         regs[rf_regd] <= rf_dataWrite;
      end
      rf_reg1 <= regs[rf_regs];
      rf_reg2 <= regs[rf_regt];
   end

   typedef struct {
      logic        rst;
      logic        clr;
      logic [3:0]  vld;
      int          pid;
      logic [4:0]  rs, rt, rd;
      logic        we;
      logic [31:0] wd;
      logic [3:0]  e_rdy;
      logic [4:0]  e_rs, e_rt, e_rd;
      logic        e_we;
      logic [31:0] e_wd;
      logic        e_rfr, e_busy, e_rv;
      logic [1:0]  e_id;
      logic [31:0] e_d1, e_d2;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input int vi, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (step %0d): got %h, expected %h", nm, vi, act, exp);
      end
   endtask

   // Requesters not named by pid carry a background payload (rs=16+i,
   // rt=20+i, rd=24+i, no write, wdata=BAD0000i) so a wrong mux shows up.
   task automatic drive(input logic rst, input logic clr, input logic [3:0] vld, input int pid,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic we, input logic [31:0] wd);
      logic [19:0]  s, t, d;
      logic [3:0]   w;
      logic [127:0] x;
      s = {5'd19, 5'd18, 5'd17, 5'd16};
      t = {5'd23, 5'd22, 5'd21, 5'd20};
      d = {5'd27, 5'd26, 5'd25, 5'd24};
      w = 4'b0000;
      x = {32'hBAD00003, 32'hBAD00002, 32'hBAD00001, 32'hBAD00000};
      if (pid >= 0) begin
         s = (s & ~(20'h1F << (pid * 5))) | (20'(rs) << (pid * 5));
         t = (t & ~(20'h1F << (pid * 5))) | (20'(rt) << (pid * 5));
         d = (d & ~(20'h1F << (pid * 5))) | (20'(rd) << (pid * 5));
         w = (w & ~(4'b0001 << pid)) | (4'(we) << pid);
         x = (x & ~(128'hFFFFFFFF << (pid * 32))) | (128'(wd) << (pid * 32));
      end
      reset         = rst;
      clear_req     = clr;
      bus.req_valid = vld;
      bus.req_rs    = s;
      bus.req_rt    = t;
      bus.req_rd    = d;
      bus.req_we    = w;
      bus.req_wdata = x;
   endtask

   task automatic check_row(input vec_t r, input int vi);
      chk("req_ready",    vi, 32'(bus.req_ready),  32'(r.e_rdy));
      chk("rf_regs",      vi, 32'(rf_regs),        32'(r.e_rs));
      chk("rf_regt",      vi, 32'(rf_regt),        32'(r.e_rt));
      chk("rf_regd",      vi, 32'(rf_regd),        32'(r.e_rd));
      chk("rf_regWrite",  vi, 32'(rf_regWrite),    32'(r.e_we));
      chk("rf_dataWrite", vi, rf_dataWrite,        r.e_wd);
      chk("rf_reset",     vi, 32'(rf_reset),       32'(r.e_rfr));
      chk("clear_busy",   vi, 32'(clear_busy),     32'(r.e_busy));
      chk("resp_valid",   vi, 32'(bus.resp_valid), 32'(r.e_rv));
      chk("resp_id",      vi, 32'(bus.resp_id),    32'(r.e_id));
      chk("resp_data1",   vi, bus.resp_data1,      r.e_d1);
      chk("resp_data2",   vi, bus.resp_data2,      r.e_d2);
   endtask

   initial begin
      //            rst  clr  vld    pid rs  rt  rd  we wd            | rdy    rs  rt  rd  we wd            rfr busy rv id d1            d2
      vq.push_back(vec_t'{1'b1,1'b0,4'hF,   0, 0,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b1,1'b0,4'hF,   0, 0,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0010,1, 9,  10, 5, 1, 32'hDEADBEEF, 4'b0010,9,  10, 5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0100,2, 5,  0,  0, 0, 32'h0,        4'b0100,5,  0,  0, 0, 32'h0,        0, 0, 1, 1, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0000,0, 0,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        0, 0, 1, 2, 32'hDEADBEEF, 32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b1000,3, 0,  0,  7, 1, 32'h11,       4'b1000,0,  0,  7, 1, 32'h11,       0, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0001,0, 7,  5,  7, 1, 32'h22,       4'b0001,7,  5,  7, 1, 32'h22,       0, 0, 1, 3, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0010,1, 7,  0,  0, 0, 32'h0,        4'b0010,7,  0,  0, 0, 32'h0,        0, 0, 1, 0, 32'h11,       32'hDEADBEEF});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0000,0, 0,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        0, 0, 1, 1, 32'h22,       32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0100,2, 0,  0,  3, 1, 32'hAA,       4'b0100,0,  0,  3, 1, 32'hAA,       0, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b1,4'b1000,3, 3,  5,  0, 0, 32'h0,        4'b1000,3,  5,  0, 0, 32'h0,        0, 0, 1, 2, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'hF,   0, 3,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        1, 1, 1, 3, 32'hAA,       32'hDEADBEEF});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0001,0, 3,  5,  0, 0, 32'h0,        4'b0001,3,  5,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0000,0, 0,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b1,4'b0000,0, 0,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b1,4'b0010,1, 1,  2,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0010,1, 1,  2,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0010,1, 1,  2,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0010,1, 1,  2,  0, 0, 32'h0,        4'b0010,1,  2,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b1,1'b0,4'hF,   0, 4,  6,  8, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'hF,   0, 4,  6,  8, 0, 32'h0,        4'b0001,4,  6,  8, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0});
      vq.push_back(vec_t'{1'b0,1'b0,4'b0000,0, 0,  0,  0, 0, 32'h0,        4'h0,   0,  0,  0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0});

      drive(1'b1, 1'b0, 4'h0, -1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);

      for (int v = 0; v < vq.size(); v++) begin
         @(posedge clk);
         #1;
         drive(vq[v].rst, vq[v].clr, vq[v].vld, vq[v].pid, vq[v].rs, vq[v].rt,
               vq[v].rd, vq[v].we, vq[v].wd);
         #3;
         check_row(vq[v], v);
      end

      // Round-robin: all four requesters valid for 8 cycles after a reset.
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 4'h0, -1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
      for (int k = 0; k < 9; k++) begin
         @(posedge clk);
         #1;
         drive(1'b0, 1'b0, (k < 8) ? 4'hF : 4'h0, -1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
         #3;
         if (k < 8) begin
            chk("rr_ready",  100 + k, 32'(bus.req_ready), 32'(1) << (k % 4));
            chk("rr_regs",   100 + k, 32'(rf_regs),       32'(16 + (k % 4)));
            chk("rr_wdata",  100 + k, rf_dataWrite,       32'hBAD00000 + 32'(k % 4));
         end
         chk("rr_resp_valid", 100 + k, 32'(bus.resp_valid), (k > 0) ? 32'd1 : 32'd0);
         if (k > 0) chk("rr_resp_id", 100 + k, 32'(bus.resp_id), 32'((k - 1) % 4));
      end

      // Register 0: write 0x55 to rd=0, then read rs=0 / rt=0.
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 4'b0001, 0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h55);
      #3;
      chk("z_ready", 200, 32'(bus.req_ready), 32'h1);
`ifdef RF_ZERO_REG_EN
      chk("z_regWrite", 200, 32'(rf_regWrite), 32'd0);
`else
      chk("z_regWrite", 200, 32'(rf_regWrite), 32'd1);
`endif
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 4'b0010, 1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
      #3;
      chk("z_ready2", 201, 32'(bus.req_ready), 32'h2);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 4'b0000, -1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
      #3;
      chk("z_resp_id", 202, 32'(bus.resp_id), 32'd1);
`ifdef RF_ZERO_REG_EN
      chk("z_data1", 202, bus.resp_data1, 32'h0);
      chk("z_data2", 202, bus.resp_data2, 32'h0);
`else
      chk("z_data1", 202, bus.resp_data1, 32'h55);
      chk("z_data2", 202, bus.resp_data2, 32'h55);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
